// File: rtl/gpio_mmio_pkg.sv
// Shared register map and default widths for the GPIO MMIO responder.
package gpio_mmio_pkg;
   localparam int DATA_W_DEF          = 32;
   localparam int GPIO_W_DEF          = 8;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   localparam logic [2:0] OFF_GPIO_OUT    = 3'd0;
   localparam logic [2:0] OFF_GPIO_IN     = 3'd1;
   localparam logic [2:0] OFF_DEVICE_OUT  = 3'd2;
   localparam logic [2:0] OFF_EDGE_STATUS = 3'd3;
   localparam logic [2:0] OFF_RISE_EN     = 3'd4;
   localparam logic [2:0] OFF_FALL_EN     = 3'd5;
endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus per-bit debounce counter; emits the accepted
// level and one-cycle pulses aligned with each accepted change.
module gpio_debounce
   import gpio_mmio_pkg::*;
#(
   parameter int GPIO_W          = GPIO_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [GPIO_W-1:0] pins,
   output logic [GPIO_W-1:0] stable,
   output logic [GPIO_W-1:0] rise_pulse,
   output logic [GPIO_W-1:0] fall_pulse
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [GPIO_W-1:0] sync_1;
   logic [GPIO_W-1:0] sync_2;
   logic [CNT_W-1:0]  cnt [GPIO_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1     <= '0;
         sync_2     <= '0;
         stable     <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int i = 0; i < GPIO_W; i++) cnt[i] <= '0;
      end else begin
         sync_1     <= pins;
         sync_2     <= sync_1;
         rise_pulse <= '0;
         fall_pulse <= '0;
         // Any return to the accepted level restarts the count, so short glitches never land.
         for (int i = 0; i < GPIO_W; i++) begin
            if (sync_2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i]     <= sync_2[i];
               cnt[i]        <= '0;
               rise_pulse[i] <= sync_2[i];
               fall_pulse[i] <= ~sync_2[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: rtl/gpio_mmio_responder.sv
// GPIO bus responder: register file, read mux, edge status with W1C, irq.
module gpio_mmio_responder
   import gpio_mmio_pkg::*;
#(
   parameter int DATA_W          = DATA_W_DEF,
   parameter int GPIO_W          = GPIO_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bus_sel,
   input  logic              bus_we,
   input  logic              bus_re,
   input  logic [2:0]        bus_addr,
   input  logic [DATA_W-1:0] bus_wdata,
   output logic [DATA_W-1:0] bus_rdata,
   output logic              bus_rvalid,
   input  logic [GPIO_W-1:0] GPIO_In,
   output logic [GPIO_W-1:0] GPIO_Out,
   output logic [GPIO_W-1:0] Device_Out,
   output logic              irq
);
   logic [GPIO_W-1:0] stable;
   logic [GPIO_W-1:0] rise_pulse;
   logic [GPIO_W-1:0] fall_pulse;
   logic [GPIO_W-1:0] edge_status;
   logic [GPIO_W-1:0] rise_en;
   logic [GPIO_W-1:0] fall_en;
   logic [GPIO_W-1:0] wdata_lo;
   logic [GPIO_W-1:0] set_vec;
   logic [GPIO_W-1:0] clr_vec;
   logic [GPIO_W-1:0] rd_mux;
   logic              wr_en;
   logic              rd_en;

   gpio_debounce #(
      .GPIO_W          (GPIO_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .pins       (GPIO_In),
      .stable     (stable),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   // A combined write+read is treated as a write only.
   assign wr_en    = bus_sel & bus_we;
   assign rd_en    = bus_sel & bus_re & ~bus_we;
   assign wdata_lo = bus_wdata[GPIO_W-1:0];
   assign set_vec  = (rise_pulse & rise_en) | (fall_pulse & fall_en);
   assign clr_vec  = (wr_en && bus_addr == OFF_EDGE_STATUS) ? wdata_lo : '0;

   always_comb begin
      rd_mux = '0;
      case (bus_addr)
         OFF_GPIO_OUT:    rd_mux = GPIO_Out;
         OFF_GPIO_IN:     rd_mux = stable;
         OFF_DEVICE_OUT:  rd_mux = Device_Out;
         OFF_EDGE_STATUS: rd_mux = edge_status;
         OFF_RISE_EN:     rd_mux = rise_en;
         OFF_FALL_EN:     rd_mux = fall_en;
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         GPIO_Out    <= '0;
         Device_Out  <= '0;
         rise_en     <= '0;
         fall_en     <= '0;
         edge_status <= '0;
         irq         <= 1'b0;
         bus_rdata   <= '0;
         bus_rvalid  <= 1'b0;
      end else begin
         if (wr_en) begin
            case (bus_addr)
               OFF_GPIO_OUT:   GPIO_Out   <= wdata_lo;
               OFF_DEVICE_OUT: Device_Out <= wdata_lo;
               OFF_RISE_EN:    rise_en    <= wdata_lo;
               OFF_FALL_EN:    fall_en    <= wdata_lo;
               default: ;
            endcase
         end
         // New events override a same-cycle W1C on the same bit.
         edge_status <= (edge_status & ~clr_vec) | set_vec;
         irq         <= |edge_status;
         bus_rvalid  <= rd_en;
         if (rd_en) bus_rdata <= DATA_W'(rd_mux);
      end
   end
endmodule

// File: tb/tb_gpio_mmio_responder.sv
// Directed bench for gpio_mmio_responder; inputs driven and outputs checked on negedge.
module tb_gpio_mmio_responder;
   logic        clk;
   logic        reset;
   logic        bus_sel;
   logic        bus_we;
   logic        bus_re;
   logic [2:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;
   logic [7:0]  GPIO_In;
   logic [7:0]  GPIO_Out;
   logic [7:0]  Device_Out;
   logic        irq;

   int checks = 0;
   int errors = 0;

   gpio_mmio_responder #(
      .DATA_W          (32),
      .GPIO_W          (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus_sel    (bus_sel),
      .bus_we     (bus_we),
      .bus_re     (bus_re),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_rvalid (bus_rvalid),
      .GPIO_In    (GPIO_In),
      .GPIO_Out   (GPIO_Out),
      .Device_Out (Device_Out),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus_sel = 1'b1; bus_we = 1'b1; bus_re = 1'b0; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_sel = 1'b0; bus_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
      bus_sel = 1'b1; bus_re = 1'b1; bus_we = 1'b0; bus_addr = a;
      @(negedge clk);
      chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
      chk(tag, bus_rdata, exp);
      bus_sel = 1'b0; bus_re = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
      bus_addr = '0; bus_wdata = '0; GPIO_In = '0;
      idle(3);
      chk("rst_gpio_out",   32'(GPIO_Out),   32'h0);
      chk("rst_device_out", 32'(Device_Out), 32'h0);
      chk("rst_rdata",      bus_rdata,       32'h0);
      chk("rst_rvalid",     32'(bus_rvalid), 32'h0);
      chk("rst_irq",        32'(irq),        32'h0);
      reset = 1'b0;
      idle(1);

      // Basic writes (upper data bits ignored) and 1-cycle read latency
      wr(3'd0, 32'hABCD_EF12);
      chk("wr_gpio_out", 32'(GPIO_Out), 32'h12);
      wr(3'd2, 32'h0000_00A5);
      chk("wr_device_out", 32'(Device_Out), 32'hA5);
      rd(3'd0, 32'h0000_0012, "rd_gpio_out");
      idle(1);
      chk("rvalid_drop", 32'(bus_rvalid), 32'h0);

      // Input latency: back-to-back reads of GPIO_IN, new value visible on the 7th
      GPIO_In = 8'h12;
      for (int k = 1; k <= 7; k++) begin
         bus_sel = 1'b1; bus_re = 1'b1; bus_addr = 3'd1;
         @(negedge clk);
         chk("lat_rvalid", 32'(bus_rvalid), 32'd1);
         chk("lat_gpio_in", bus_rdata, (k == 7) ? 32'h12 : 32'h0);
      end
      bus_sel = 1'b0; bus_re = 1'b0;
      idle(1);
      chk("lat_rvalid_end", 32'(bus_rvalid), 32'h0);

      // Glitch rejection with all rises enabled
      wr(3'd4, 32'h0000_00FF);
      GPIO_In = 8'h13;
      idle(2);
      GPIO_In = 8'h12;
      idle(10);
      rd(3'd1, 32'h12, "glitch_gpio_in");
      rd(3'd3, 32'h00, "glitch_status");
      chk("glitch_irq", 32'(irq), 32'h0);

      // Rise on bit1 recorded, falls ignored, W1C clears
      wr(3'd4, 32'h0000_0002);
      wr(3'd5, 32'h0000_0000);
      GPIO_In = 8'h00;
      idle(10);
      rd(3'd3, 32'h00, "fall_disabled_status");
      GPIO_In = 8'h02;
      idle(10);
      rd(3'd3, 32'h02, "rise_status");
      chk("rise_irq", 32'(irq), 32'h1);
      GPIO_In = 8'h00;
      idle(10);
      rd(3'd3, 32'h02, "after_fall_status");
      wr(3'd3, 32'h0000_0002);
      rd(3'd3, 32'h00, "w1c_status");
      chk("w1c_irq", 32'(irq), 32'h0);

      // W1C coincident with a fresh rise on bit1: set wins
      GPIO_In = 8'h02;
      idle(6);
      wr(3'd3, 32'h0000_0002);
      chk("race_irq_lag", 32'(irq), 32'h0);
      rd(3'd3, 32'h02, "race_status");
      chk("race_irq", 32'(irq), 32'h1);

      // Simultaneous we/re: write only, no rvalid
      bus_sel = 1'b1; bus_we = 1'b1; bus_re = 1'b1; bus_addr = 3'd0; bus_wdata = 32'h3C;
      @(negedge clk);
      chk("wr_rd_rvalid", 32'(bus_rvalid), 32'h0);
      chk("wr_rd_gpio_out", 32'(GPIO_Out), 32'h3C);
      bus_sel = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
      wr(3'd7, 32'h0000_00FF);
      rd(3'd7, 32'h0, "unmapped");
      rd(3'd4, 32'h02, "rise_en_rb");
      rd(3'd2, 32'hA5, "device_out_rb");
      bus_re = 1'b1; bus_addr = 3'd0;
      @(negedge clk);
      chk("nosel_rvalid", 32'(bus_rvalid), 32'h0);
      chk("nosel_rdata_hold", bus_rdata, 32'hA5);
      bus_re = 1'b0;

      // Reset mid-debounce and mid-read
      GPIO_In = 8'hFF;
      idle(3);
      bus_sel = 1'b1; bus_re = 1'b1; bus_addr = 3'd0;
      reset = 1'b1;
      idle(2);
      chk("mid_rst_rvalid",     32'(bus_rvalid), 32'h0);
      chk("mid_rst_rdata",      bus_rdata,       32'h0);
      chk("mid_rst_gpio_out",   32'(GPIO_Out),   32'h0);
      chk("mid_rst_device_out", 32'(Device_Out), 32'h0);
      chk("mid_rst_irq",        32'(irq),        32'h0);
      bus_sel = 1'b0; bus_re = 1'b0;
      reset = 1'b0;
      rd(3'd1, 32'h00, "post_rst_gpio_in");
      rd(3'd3, 32'h00, "post_rst_status");
      rd(3'd5, 32'h00, "post_rst_fall_en");
      idle(10);
      rd(3'd1, 32'hFF, "post_rst_settled");
      rd(3'd3, 32'h00, "post_rst_no_event");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
